spart_fifo_driver: RTL and testbench
====================================

SPART_FIFO_DRIVER -- requirements
Module: spart_fifo_driver

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25000000, system clock frequency in Hz.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, echo buffer depth; power of two, minimum 2.
REQ-003 SHALL have parameter CNT_W, default 16, width of received-byte counter.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port br_cfg  input  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400.
REQ-007 SHALL have port upcase  input  1  1 = convert ASCII a-z to A-Z on transmit.
REQ-008 SHALL have port rda  input  1  SPART receive data available.
REQ-009 SHALL have port tbr  input  1  SPART transmit buffer ready.
REQ-010 SHALL have port iocs  output  1  SPART chip select.
REQ-011 SHALL have port iorw  output  1  1 = read from SPART, 0 = write.
REQ-012 SHALL have port ioaddr  output  2  00 data, 01 status, 10 DB low, 11 DB high.
REQ-013 SHALL have port databus  inout  8  bidirectional SPART bus; high-Z when not driving.
REQ-014 SHALL have port busy  output  1  1 while divisor programming in progress.
REQ-015 SHALL have port fifo_count  output  clog2(FIFO_DEPTH)+1  bytes held in buffer.
REQ-016 SHALL have port rx_total  output  CNT_W  bytes read from SPART since reset.

Function
REQ-017 SHALL implement states DBL, DBH, IDLE, RX, TX, HOLD; one SPART bus transaction per cycle.
REQ-018 Divisor SHALL be floor(CLK_HZ / (16*baud)), 16 bits, computed from parameters; at 25 MHz: 325, 162, 81, 40.
REQ-019 DBL: iocs=1, iorw=0, ioaddr=10, drive divisor[7:0], latch br_cfg into br_q; next DBH.
REQ-020 DBH: iocs=1, iorw=0, ioaddr=11, drive divisor[15:8] for br_q; next IDLE.
REQ-021 busy SHALL be 1 exactly in DBL and DBH.
REQ-022 IDLE priority: br_cfg != br_q -> DBL; else rda and FIFO not full -> RX; else tbr and FIFO not empty -> TX; else stay; iocs=0.
REQ-023 RX: iocs=1, iorw=1, ioaddr=00, databus high-Z; sample databus at cycle end and push to FIFO; rx_total increments, wrapping at 2^CNT_W; next HOLD.
REQ-024 TX: iocs=1, iorw=0, ioaddr=00, drive FIFO head (converted if upcase=1, 0x61-0x7A minus 0x20, other bytes unchanged); pop; next HOLD.
REQ-025 upcase SHALL be sampled in the TX cycle itself, not at push time.
REQ-026 HOLD: iocs=0, ignore rda/tbr for one cycle; next IDLE.
REQ-027 databus SHALL be driven only in DBL, DBH, TX; never in same cycle as iorw=1.
REQ-028 FIFO full with rda=1: no read; byte stays in SPART until a TX frees space.
REQ-029 FIFO empty with tbr=1: no write.
REQ-030 Push and pop SHALL never occur in the same cycle; FIFO pointers wrap modulo FIFO_DEPTH, order preserved.
REQ-031 br_cfg change SHALL reprogram only from IDLE; FIFO contents kept across reprogramming.
REQ-032 Outputs iocs, iorw, ioaddr SHALL be combinational from state; no status-register polling required.

Reset
REQ-033 While rst=0 at a clock edge: state<=DBL, FIFO emptied, rx_total<=0, br_q<=00.
REQ-034 While rst=0: iocs=0, iorw=0, ioaddr=00, busy=0, databus high-Z, regardless of state.
REQ-035 First cycle after rst rises SHALL be DBL; reset mid-RX/TX SHALL abort without pushing or popping.

Verification
REQ-036 Reset then br_cfg=01 -> DBL drives 0xA2 @ ioaddr 10, next cycle DBH drives 0x00 @ ioaddr 11, busy high 2 cycles.
REQ-037 rda pulse with databus=0x61, upcase=1, tbr=1 -> RX, HOLD, IDLE, TX drives 0x41; rx_total=1, fifo_count back to 0.
REQ-038 tbr=0, rda held, 9 bytes offered, depth 8 -> exactly 8 reads, fifo_count=8, no 9th RX; tbr=1 -> bytes emitted in order.
REQ-039 br_cfg 00->11 while FIFO holds 3 bytes -> DBL 0x28, DBH 0x00, FIFO still 3, then transmits resume.
REQ-040 rst low during TX cycle -> next cycle bus idle, fifo_count=0, rx_total=0; after release DBL first.
REQ-041 rx_total at 0xFFFF plus one RX -> 0x0000.

Source files
------------

// File: rtl/spart_fifo_driver.sv
// spart_fifo_driver: programs the SPART baud divisor, then echoes received bytes through a FIFO back to the transmitter
module spart_fifo_driver #(
  parameter int CLK_HZ     = 25000000,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    br_cfg,
  input  logic                          upcase,
  input  logic                          rda,
  input  logic                          tbr,
  output logic                          iocs,
  output logic                          iorw,
  output logic [1:0]                    ioaddr,
  inout  wire  [7:0]                    databus,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]              rx_total
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {DBL, DBH, IDLE, RX, TX, HOLD} state_t;
  state_t state_q, state_d;
  logic [1:0] br_q;
  logic [AW:0] wr_q, rd_q;
  logic [CNT_W-1:0] rx_total_q;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [15:0] div_lo, div_hi;
  logic [7:0] head, tx_byte, dout;
  logic full, empty, drv;
  function automatic logic [15:0] divisor(input logic [1:0] s);
    return 16'(CLK_HZ / (16 * (4800 << s)));
  endfunction
  assign div_lo     = divisor(br_cfg);
  assign div_hi     = divisor(br_q);
  assign fifo_count = wr_q - rd_q;
  assign full       = fifo_count == (AW+1)'(FIFO_DEPTH);
  assign empty      = fifo_count == '0;
  assign head       = mem_q[rd_q[AW-1:0]];
  assign tx_byte    = (upcase && head >= 8'h61 && head <= 8'h7A) ? head - 8'h20 : head;
  assign dout       = state_q == DBL ? div_lo[7:0] : state_q == DBH ? div_hi[15:8] : tx_byte;
  assign drv        = rst && (state_q == DBL || state_q == DBH || state_q == TX);
  assign databus    = drv ? dout : 8'bz;
  assign iocs       = rst && state_q != IDLE && state_q != HOLD;
  assign iorw       = rst && state_q == RX;
  assign ioaddr     = !rst ? 2'b00 : state_q == DBL ? 2'b10 : state_q == DBH ? 2'b11 : 2'b00;
  assign busy       = rst && (state_q == DBL || state_q == DBH);
  assign rx_total   = rx_total_q;
  always_comb begin
    state_d = IDLE;
    case (state_q)
      DBL:     state_d = DBH;
      IDLE:    state_d = br_cfg != br_q ? DBL : (rda && !full) ? RX : (tbr && !empty) ? TX : IDLE;
      RX, TX:  state_d = HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= DBL;
      br_q       <= 2'b00;
      wr_q       <= '0;
      rd_q       <= '0;
      rx_total_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DBL) br_q <= br_cfg;
      if (state_q == RX) begin
        wr_q       <= wr_q + (AW+1)'(1);
        rx_total_q <= rx_total_q + CNT_W'(1);
      end
      if (state_q == TX) rd_q <= rd_q + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk)
    if (rst && state_q == RX) mem_q[wr_q[AW-1:0]] <= databus;
endmodule

// File: tb/tb_spart_fifo_driver.sv
// tb_spart_fifo_driver: directed scenario tests for spart_fifo_driver
module tb_spart_fifo_driver;
  logic clk = 0, rst = 0, upcase = 0, rda = 0, tbr = 0;
  logic [1:0] br_cfg = 2'b01;
  logic tb_en = 0;
  logic [7:0] tb_data = 8'h00;
  wire iocs, iorw, busy;
  wire [1:0] ioaddr;
  wire [7:0] databus;
  wire [3:0] fifo_count;
  wire [3:0] rx_total;
  int errors = 0, checks = 0;
  assign databus = tb_en ? tb_data : 8'hzz;
  always #5 clk = ~clk;
  spart_fifo_driver #(.CLK_HZ(25000000), .FIFO_DEPTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .upcase(upcase), .rda(rda), .tbr(tbr),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus), .busy(busy),
    .fifo_count(fifo_count), .rx_total(rx_total));
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 0; tb_en = 1; tb_data = 8'hC3;
    cyc(); cyc();
    checks++; if (iocs !== 1'b0) begin errors++; $display("FAIL rst_iocs got=%b want=0", iocs); end
    checks++; if (iorw !== 1'b0) begin errors++; $display("FAIL rst_iorw got=%b want=0", iorw); end
    checks++; if (ioaddr !== 2'b00) begin errors++; $display("FAIL rst_ioaddr got=%b want=00", ioaddr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (databus !== 8'hC3) begin errors++; $display("FAIL rst_bus_released got=%h want=c3", databus); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL rst_fifo_count got=%0d want=0", fifo_count); end
    checks++; if (rx_total !== 4'd0) begin errors++; $display("FAIL rst_rx_total got=%0d want=0", rx_total); end
    tb_en = 0;
  endtask
  task automatic test_divisor;
    rst = 1; #1;
    checks++; if (iocs !== 1'b1 || iorw !== 1'b0 || ioaddr !== 2'b10) begin errors++; $display("FAIL dbl_ctrl got=%b%b%b want=1010", iocs, iorw, ioaddr); end
    checks++; if (databus !== 8'hA2) begin errors++; $display("FAIL dbl_data got=%h want=a2", databus); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dbl_busy got=%b want=1", busy); end
    cyc();
    checks++; if (iocs !== 1'b1 || iorw !== 1'b0 || ioaddr !== 2'b11) begin errors++; $display("FAIL dbh_ctrl got=%b%b%b want=1011", iocs, iorw, ioaddr); end
    checks++; if (databus !== 8'h00) begin errors++; $display("FAIL dbh_data got=%h want=00", databus); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dbh_busy got=%b want=1", busy); end
    cyc();
    checks++; if (busy !== 1'b0 || iocs !== 1'b0) begin errors++; $display("FAIL idle_after_db got busy=%b iocs=%b want 0 0", busy, iocs); end
  endtask
  task automatic test_echo;
    tb_en = 1; tb_data = 8'h61; rda = 1; upcase = 1; tbr = 1;
    cyc();
    checks++; if (iocs !== 1'b1 || iorw !== 1'b1 || ioaddr !== 2'b00) begin errors++; $display("FAIL rx_ctrl got=%b%b%b want=1100", iocs, iorw, ioaddr); end
    checks++; if (databus !== 8'h61) begin errors++; $display("FAIL rx_bus_released got=%h want=61", databus); end
    cyc();
    tb_en = 0; rda = 0;
    checks++; if (iocs !== 1'b0 || rx_total !== 4'd1 || fifo_count !== 4'd1) begin errors++; $display("FAIL hold_after_rx got iocs=%b rx=%0d cnt=%0d want 0 1 1", iocs, rx_total, fifo_count); end
    cyc();
    checks++; if (iocs !== 1'b0) begin errors++; $display("FAIL idle_after_hold got=%b want=0", iocs); end
    cyc();
    checks++; if (iocs !== 1'b1 || iorw !== 1'b0 || ioaddr !== 2'b00 || databus !== 8'h41) begin errors++; $display("FAIL tx_upcase got=%b%b%b %h want=1000 41", iocs, iorw, ioaddr, databus); end
    cyc();
    tbr = 0;
    checks++; if (fifo_count !== 4'd0 || iocs !== 1'b0) begin errors++; $display("FAIL after_tx got cnt=%0d iocs=%b want 0 0", fifo_count, iocs); end
    cyc();
  endtask
  task automatic test_fill;
    int n;
    logic [7:0] src [9];
    src = '{8'h61, 8'h7A, 8'h60, 8'h7B, 8'h41, 8'h5A, 8'h00, 8'hFF, 8'h62};
    n = 0; upcase = 0; tbr = 0; rda = 1; tb_en = 1; tb_data = src[0];
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (iocs && iorw) begin
        if (n < 9) tb_data = src[n];
        n++;
      end
    end
    rda = 0; tb_en = 0;
    checks++; if (n !== 8) begin errors++; $display("FAIL fill_reads got=%0d want=8", n); end
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL fill_count got=%0d want=8", fifo_count); end
    checks++; if (rx_total !== 4'd9) begin errors++; $display("FAIL fill_rx_total got=%0d want=9", rx_total); end
  endtask
  task automatic test_drain;
    int k, stray;
    logic [7:0] exp_b [8];
    exp_b = '{8'h41, 8'h5A, 8'h60, 8'h7B, 8'h41, 8'h5A, 8'h00, 8'hFF};
    k = 0; stray = 0; upcase = 1; tbr = 1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (iocs && !iorw && ioaddr == 2'b00) begin
        if (k < 8) begin
          checks++; if (databus !== exp_b[k]) begin errors++; $display("FAIL drain_byte%0d got=%h want=%h", k, databus, exp_b[k]); end
        end
        k++;
      end
    end
    checks++; if (k !== 8) begin errors++; $display("FAIL drain_writes got=%0d want=8", k); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL drain_count got=%0d want=0", fifo_count); end
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (iocs) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL empty_no_write got=%0d want=0", stray); end
    tbr = 0;
  endtask
  task automatic test_rebaud;
    int n, k, found;
    logic [7:0] src [3];
    src = '{8'h10, 8'h20, 8'h30};
    n = 0; k = 0; found = 0; tbr = 0; rda = 1; tb_en = 1; tb_data = src[0];
    for (int i = 0; i < 30 && n < 3; i++) begin
      cyc();
      if (iocs && iorw) begin
        tb_data = src[n];
        n++;
        if (n == 3) rda = 0;
      end
    end
    cyc();
    tb_en = 0;
    checks++; if (n !== 3) begin errors++; $display("FAIL rebaud_fill got=%0d want=3", n); end
    br_cfg = 2'b11;
    for (int i = 0; i < 6 && found == 0; i++) begin
      cyc();
      if (busy) found = 1;
    end
    checks++; if (found !== 1) begin errors++; $display("FAIL rebaud_timeout got=%0d want=1", found); end
    checks++; if (ioaddr !== 2'b10 || databus !== 8'h28) begin errors++; $display("FAIL rebaud_dbl got=%b %h want=10 28", ioaddr, databus); end
    cyc();
    checks++; if (ioaddr !== 2'b11 || databus !== 8'h00 || busy !== 1'b1) begin errors++; $display("FAIL rebaud_dbh got=%b %h %b want=11 00 1", ioaddr, databus, busy); end
    checks++; if (fifo_count !== 4'd3) begin errors++; $display("FAIL rebaud_kept got=%0d want=3", fifo_count); end
    cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rebaud_done got=%b want=0", busy); end
    tbr = 1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (iocs && !iorw && ioaddr == 2'b00) begin
        if (k < 3) begin
          checks++; if (databus !== src[k]) begin errors++; $display("FAIL rebaud_tx%0d got=%h want=%h", k, databus, src[k]); end
        end
        k++;
      end
    end
    tbr = 0;
    checks++; if (k !== 3) begin errors++; $display("FAIL rebaud_tx_count got=%0d want=3", k); end
    checks++; if (rx_total !== 4'd12) begin errors++; $display("FAIL rebaud_rx_total got=%0d want=12", rx_total); end
  endtask
  task automatic test_wrap;
    int n;
    n = 0; tbr = 0; rda = 1; tb_en = 1; tb_data = 8'h55;
    for (int i = 0; i < 30 && n < 3; i++) begin
      cyc();
      if (iocs && iorw) begin
        n++;
        if (n == 3) rda = 0;
      end
    end
    cyc();
    checks++; if (rx_total !== 4'hF) begin errors++; $display("FAIL wrap_max got=%h want=f", rx_total); end
    rda = 1; n = 0;
    for (int i = 0; i < 10 && n < 1; i++) begin
      cyc();
      if (iocs && iorw) begin
        n++;
        rda = 0;
      end
    end
    cyc();
    tb_en = 0;
    checks++; if (rx_total !== 4'h0) begin errors++; $display("FAIL wrap_zero got=%h want=0", rx_total); end
    checks++; if (fifo_count !== 4'd4) begin errors++; $display("FAIL wrap_count got=%0d want=4", fifo_count); end
  endtask
  task automatic test_reset_mid_tx;
    int found;
    found = 0; tbr = 1;
    for (int i = 0; i < 10 && found == 0; i++) begin
      cyc();
      if (iocs && !iorw && ioaddr == 2'b00) found = 1;
    end
    checks++; if (found !== 1) begin errors++; $display("FAIL midtx_timeout got=%0d want=1", found); end
    rst = 0;
    cyc();
    tb_en = 1; tb_data = 8'h3C; #1;
    checks++; if (iocs !== 1'b0 || busy !== 1'b0 || databus !== 8'h3C) begin errors++; $display("FAIL midtx_idle got iocs=%b busy=%b bus=%h want 0 0 3c", iocs, busy, databus); end
    checks++; if (fifo_count !== 4'd0 || rx_total !== 4'd0) begin errors++; $display("FAIL midtx_cleared got cnt=%0d rx=%0d want 0 0", fifo_count, rx_total); end
    tb_en = 0; tbr = 0;
    cyc();
    rst = 1; #1;
    checks++; if (busy !== 1'b1 || ioaddr !== 2'b10 || databus !== 8'h28) begin errors++; $display("FAIL midtx_dbl got busy=%b addr=%b bus=%h want 1 10 28", busy, ioaddr, databus); end
    cyc(); cyc(); cyc();
    checks++; if (iocs !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midtx_settle got iocs=%b busy=%b want 0 0", iocs, busy); end
  endtask
  initial begin
    test_reset();
    test_divisor();
    test_echo();
    test_fill();
    test_drain();
    test_rebaud();
    test_wrap();
    test_reset_mid_tx();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
